trig_pulse_gen_mc: RTL and testbench
====================================

Name: trig_pulse_gen_mc

Overview:
Multi-channel, parametrised successor to the single-output transmit trigger. The block generates the pulse-repetition (PRF) timebase and one programmable-width, programmable-delay transmit trigger per transducer channel, plus a shot-synchronous sync strobe for the ADC capture path. It supports continuous, single-shot and burst modes. It sits between the control register file and the pulser drivers / acquisition sequencer.

Parameters:
NUM_CH, 4, number of trigger channels
CNT_W, 24, width of PRF period counter (period in clk ticks)
PW_W, 10, width of pulse-width field (ticks)
DLY_W, 12, width of per-channel delay field (ticks)
BURST_W, 8, width of burst shot count
SHOT_W, 16, width of shot counter output

Ports:
clk  in  1  system clock (50 MHz nominal)
rst  in  1  asynchronous, active-high reset
start  in  1  single-cycle request to begin a sequence
stop  in  1  single-cycle request to end after the current shot
cfg_mode  in  2  0 continuous, 1 single shot, 2 burst, 3 reserved
cfg_period  in  CNT_W  shot period in ticks
cfg_width  in  PW_W  trigger high time in ticks
cfg_delay  in  NUM_CH*DLY_W  per-channel delay from shot start; channel k at [k*DLY_W +: DLY_W]
cfg_burst  in  BURST_W  shots per burst (mode 2)
ch_en  in  NUM_CH  per-channel enable
trig_out  out  NUM_CH  registered trigger pulses
sync_out  out  1  one-tick strobe at each shot start
busy  out  1  sequence active (output-aligned)
shot_cnt  out  SHOT_W  shots started since last accepted start
cfg_err  out  1  last start rejected for invalid config

Behaviour:
- Reset (async, while rst=1): trig_out=0, sync_out=0, busy=0, shot_cnt=0, cfg_err=0, FSM=IDLE, cnt=0.
- FSM states: IDLE, RUN, LAST.
  - IDLE: a start is accepted if the config is valid. The config is valid when all of these hold: cfg_mode != 3; cfg_width != 0; cfg_period >= 2; max over enabled k of cfg_delay[k] + cfg_width <= cfg_period; and cfg_burst != 0 when cfg_mode = 2.
  - On an invalid start: cfg_err <= 1 and the FSM stays in IDLE.
  - On an accepted start: cfg_err <= 0; cfg_mode, cfg_period, cfg_width, cfg_delay, cfg_burst and ch_en are latched into shadow registers; cnt <= 0; shot_cnt <= 0; the FSM goes to RUN (or to LAST when mode = 1).
  - RUN: cnt increments each tick. At cnt = period-1, cnt wraps to 0 and the next shot begins. Shadow registers are re-latched from the live inputs at the wrap only if the live config is valid; otherwise the old shadow values are kept.
  - RUN -> LAST: at the start of the final shot. In burst mode the final shot is the one where shot_cnt reaches cfg_burst; a stop also sends the FSM to LAST.
  - LAST: runs the current shot to cnt = period-1, then goes to IDLE. Pulses are never truncated by stop.
- Output timing: let t=0 be the cycle after the accepting edge, so the first RUN cycle has cnt=0. All outputs are registered, with one tick of latency from cnt:
  - sync_out(t+1) = active && cnt==0
  - trig_out[k](t+1) = active && en[k] && cnt >= d_k && cnt < d_k + width
  - busy(t+1) = active
  - Here "active" means the FSM is in RUN or LAST.
- shot_cnt increments at every cnt==0 while active, wraps 2^SHOT_W-1 -> 0, and holds after the sequence ends.
- start while RUN/LAST: ignored. start and stop in the same IDLE cycle: stop wins, start ignored, cfg_err unchanged. stop in IDLE: no effect.
- Arithmetic: the compare d_k + width uses CNT_W+1 bits, with no overflow wrap.
- Reset mid-pulse: all outputs drop immediately (async). No pulse resumes after reset release without a new start.

Decomposition:
- Shared package ufd_trig_pkg: mode encodings (MODE_CONT, MODE_SINGLE, MODE_BURST), FSM state enum, and a default 50 MHz tick constant (20 ns).
- One sub-module: trig_chan. It contains the per-channel delay/width comparator and output register and is instantiated NUM_CH times. The FSM, counter, config check and shadow registers stay in the top module.

Test Plan:
1. Continuous run: period=100, width=5, delays 0/10/20/30, ch_en=4'hF; start at t=-1. Required response: sync_out high at t=1,101,201; trig_out[0] high t=1..5; trig_out[1] high t=11..15; trig_out[3] high t=31..35; the pattern repeats every 100 ticks; busy high from t=1.
2. Single shot, same config: exactly one sync_out and one pulse per channel. busy is high t=1..100 and low from t=101; shot_cnt=1.
3. Burst: mode=2, burst=3, period=50. Required response: 3 sync strobes (t=1,51,101); shot_cnt=3; busy falls at t=151. Then start with width=0: cfg_err=1, no activity, shot_cnt stays 3.
4. Stop mid-shot: continuous, stop at cnt=40 of shot 2. Shot 2 completes, including the ch3 pulse at cnt 30..34. No third sync; busy low after period end.
5. Invalid config: period=30, delay[2]=28, width=5, ch2 enabled: cfg_err=1, outputs stay 0. Disable ch2 and start again: start accepted, cfg_err=0.
6. Reset mid-pulse: assert rst during the trig_out[0] high time. All outputs go 0 in the same cycle; after release the block is idle until the next start.

Source files
------------

// File: rtl/ufd_trig_pkg.sv
// Shared encodings for the transmit trigger family: operating modes, sequencer
// states and the nominal clock tick.
package ufd_trig_pkg;

  typedef enum logic [1:0] {
    MODE_CONT   = 2'd0,
    MODE_SINGLE = 2'd1,
    MODE_BURST  = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LAST = 2'd2
  } state_e;

  localparam int unsigned TICK_NS = 20;

endpackage

// File: rtl/trig_chan.sv
// One trigger channel: compares the shot counter against this channel's
// delay/width window and registers the result onto the pulser output.
module trig_chan
  import ufd_trig_pkg::*;
#(
  parameter int CNT_W = 24,
  parameter int PW_W  = 10,
  parameter int DLY_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             active,
  input  logic             en,
  input  logic [CNT_W-1:0] cnt,
  input  logic [DLY_W-1:0] delay,
  input  logic [PW_W-1:0]  width,
  output logic             trig
);

  logic [CNT_W:0] cnt_x;
  logic [CNT_W:0] win_lo;
  logic [CNT_W:0] win_hi;

  // One extra bit keeps delay + width from wrapping near the top of the range.
  always_comb begin
    cnt_x  = (CNT_W+1)'(cnt);
    win_lo = (CNT_W+1)'(delay);
    win_hi = win_lo + (CNT_W+1)'(width);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) trig <= 1'b0;
    else     trig <= active && en && (cnt_x >= win_lo) && (cnt_x < win_hi);
  end

endmodule

// File: rtl/trig_pulse_gen_mc.sv
// Multi-channel PRF timebase: sequencer FSM, period counter, config validation
// and shadow registers, driving NUM_CH delayed/width-programmable triggers.
module trig_pulse_gen_mc
  import ufd_trig_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 24,
  parameter int PW_W    = 10,
  parameter int DLY_W   = 12,
  parameter int BURST_W = 8,
  parameter int SHOT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  input  logic [1:0]              cfg_mode,
  input  logic [CNT_W-1:0]        cfg_period,
  input  logic [PW_W-1:0]         cfg_width,
  input  logic [NUM_CH*DLY_W-1:0] cfg_delay,
  input  logic [BURST_W-1:0]      cfg_burst,
  input  logic [NUM_CH-1:0]       ch_en,
  output logic [NUM_CH-1:0]       trig_out,
  output logic                    sync_out,
  output logic                    busy,
  output logic [SHOT_W-1:0]       shot_cnt,
  output logic                    cfg_err
);

  state_e                    state, state_nxt;
  logic [CNT_W-1:0]          cnt, cnt_nxt;
  logic [SHOT_W-1:0]         shot_nxt, shot_inc;
  logic                      err_nxt, load_cfg, live_ok, active, last_tick;

  mode_e                     mode_sh;
  logic [CNT_W-1:0]          period_sh;
  logic [PW_W-1:0]           width_sh;
  logic [NUM_CH*DLY_W-1:0]   delay_sh;
  logic [BURST_W-1:0]        burst_sh;
  logic [NUM_CH-1:0]         en_sh;

  // Live config check; every enabled channel's window must fit inside the period.
  always_comb begin
    live_ok = (mode_e'(cfg_mode) != MODE_RSVD) && (cfg_width != '0) &&
              (cfg_period >= CNT_W'(2)) &&
              !((mode_e'(cfg_mode) == MODE_BURST) && (cfg_burst == '0));
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_en[k] && (((CNT_W+1)'(cfg_delay[k*DLY_W +: DLY_W]) + (CNT_W+1)'(cfg_width)) >
                       (CNT_W+1)'(cfg_period)))
        live_ok = 1'b0;
    end
  end

  assign active    = (state != ST_IDLE);
  assign last_tick = (cnt == period_sh - CNT_W'(1));
  assign shot_inc  = shot_cnt + SHOT_W'(1);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    shot_nxt  = shot_cnt;
    err_nxt   = cfg_err;
    load_cfg  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start && !stop) begin
          if (live_ok) begin
            err_nxt   = 1'b0;
            load_cfg  = 1'b1;
            cnt_nxt   = '0;
            shot_nxt  = '0;
            state_nxt = (mode_e'(cfg_mode) == MODE_SINGLE) ? ST_LAST : ST_RUN;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      ST_RUN: begin
        cnt_nxt  = last_tick ? '0 : cnt + CNT_W'(1);
        load_cfg = last_tick && live_ok;
        if (cnt == '0) begin
          shot_nxt = shot_inc;
          if ((mode_sh == MODE_SINGLE) ||
              ((mode_sh == MODE_BURST) && (shot_inc == SHOT_W'(burst_sh))))
            state_nxt = ST_LAST;
        end
        if (stop) state_nxt = ST_LAST;
      end
      ST_LAST: begin
        cnt_nxt = last_tick ? '0 : cnt + CNT_W'(1);
        if (cnt == '0) shot_nxt = shot_inc;
        if (last_tick) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      shot_cnt <= '0;
      cfg_err  <= 1'b0;
      sync_out <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      shot_cnt <= shot_nxt;
      cfg_err  <= err_nxt;
      sync_out <= active && (cnt == '0);
      busy     <= active;
    end
  end

  // NOTE: shadow registers are few flops, so they are reset too; nothing reads stale X after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_sh   <= MODE_CONT;
      period_sh <= '0;
      width_sh  <= '0;
      delay_sh  <= '0;
      burst_sh  <= '0;
      en_sh     <= '0;
    end else if (load_cfg) begin
      mode_sh   <= mode_e'(cfg_mode);
      period_sh <= cfg_period;
      width_sh  <= cfg_width;
      delay_sh  <= cfg_delay;
      burst_sh  <= cfg_burst;
      en_sh     <= ch_en;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    trig_chan #(
      .CNT_W (CNT_W),
      .PW_W  (PW_W),
      .DLY_W (DLY_W)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .active (active),
      .en     (en_sh[k]),
      .cnt    (cnt),
      .delay  (delay_sh[k*DLY_W +: DLY_W]),
      .width  (width_sh),
      .trig   (trig_out[k])
    );
  end

endmodule

// File: tb/tb_trig_pulse_gen_mc.sv
// Scoreboard bench for trig_pulse_gen_mc: per-cycle expected output vectors are
// queued when a sequence is launched and popped against the DUT each cycle.
module tb_trig_pulse_gen_mc;

  localparam int NUM_CH  = 4;
  localparam int CNT_W   = 24;
  localparam int PW_W    = 10;
  localparam int DLY_W   = 12;
  localparam int BURST_W = 8;
  localparam int SHOT_W  = 16;

  typedef struct packed {
    logic [NUM_CH-1:0] trig;
    logic              sync;
    logic              busy;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start, stop;
  logic [1:0]              cfg_mode;
  logic [CNT_W-1:0]        cfg_period;
  logic [PW_W-1:0]         cfg_width;
  logic [NUM_CH*DLY_W-1:0] cfg_delay;
  logic [BURST_W-1:0]      cfg_burst;
  logic [NUM_CH-1:0]       ch_en;
  logic [NUM_CH-1:0]       trig_out;
  logic                    sync_out, busy, cfg_err;
  logic [SHOT_W-1:0]       shot_cnt;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  trig_pulse_gen_mc #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .PW_W(PW_W),
    .DLY_W(DLY_W), .BURST_W(BURST_W), .SHOT_W(SHOT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .cfg_mode   (cfg_mode),
    .cfg_period (cfg_period),
    .cfg_width  (cfg_width),
    .cfg_delay  (cfg_delay),
    .cfg_burst  (cfg_burst),
    .ch_en      (ch_en),
    .trig_out   (trig_out),
    .sync_out   (sync_out),
    .busy       (busy),
    .shot_cnt   (shot_cnt),
    .cfg_err    (cfg_err)
  );

  // Expected outputs at tick t (t=1 is the first tick a registered output can move).
  function automatic exp_t model(input int t, input int p, input int w,
                                 input logic [NUM_CH*DLY_W-1:0] dly,
                                 input logic [NUM_CH-1:0] en, input int nshots);
    exp_t e;
    int   s, c, d;
    e = '0;
    s = (t - 1) / p;
    c = (t - 1) % p;
    if (s < nshots) begin
      e.busy = 1'b1;
      e.sync = (c == 0);
      for (int k = 0; k < NUM_CH; k++) begin
        d = int'(dly[k*DLY_W +: DLY_W]);
        e.trig[k] = en[k] && (c >= d) && (c < d + w);
      end
    end
    return e;
  endfunction

  task automatic check_scalar(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Launch a sequence with one start pulse and compare ncyc output ticks.
  task automatic run_seq(input string name, input logic [1:0] mode, input int p, input int w,
                         input logic [NUM_CH*DLY_W-1:0] dly, input logic [NUM_CH-1:0] en,
                         input int burst, input int nshots, input int stop_at, input int ncyc);
    exp_t e, got;
    cfg_mode   = mode;
    cfg_period = CNT_W'(p);
    cfg_width  = PW_W'(w);
    cfg_delay  = dly;
    cfg_burst  = BURST_W'(burst);
    ch_en      = en;
    for (int t = 1; t <= ncyc; t++) sb.push_back(model(t, p, w, dly, en, nshots));
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 1; t <= ncyc; t++) begin
      @(negedge clk);
      stop = (t == stop_at);
      e    = sb.pop_front();
      got  = '{trig: trig_out, sync: sync_out, busy: busy};
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL %s t=%0d: got trig=%b sync=%b busy=%b, want trig=%b sync=%b busy=%b",
                 name, t, got.trig, got.sync, got.busy, e.trig, e.sync, e.busy);
      end
    end
    stop = 1'b0;
  endtask

  localparam logic [NUM_CH*DLY_W-1:0] DLY_STD = {12'd30, 12'd20, 12'd10, 12'd0};
  localparam logic [NUM_CH*DLY_W-1:0] DLY_BAD = {12'd20, 12'd28, 12'd10, 12'd0};
  localparam logic [NUM_CH*DLY_W-1:0] DLY_EDG = {12'd20, 12'd25, 12'd10, 12'd0};

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    cfg_mode = '0; cfg_period = '0; cfg_width = '0; cfg_delay = '0; cfg_burst = '0; ch_en = '0;
    repeat (3) @(negedge clk);
    check_scalar("reset trig_out", 32'(trig_out), 0);
    check_scalar("reset sync_out", 32'(sync_out), 0);
    check_scalar("reset busy", 32'(busy), 0);
    check_scalar("reset shot_cnt", 32'(shot_cnt), 0);
    check_scalar("reset cfg_err", 32'(cfg_err), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_continuous();
    // stop lands on cnt=0 of the fourth shot, which still completes
    run_seq("continuous", 2'd0, 100, 5, DLY_STD, 4'hF, 1, 4, 300, 420);
    check_scalar("continuous shot_cnt", 32'(shot_cnt), 4);
  endtask

  task automatic test_single();
    run_seq("single", 2'd1, 100, 5, DLY_STD, 4'hF, 1, 1, -1, 130);
    check_scalar("single shot_cnt", 32'(shot_cnt), 1);
  endtask

  task automatic test_burst();
    run_seq("burst", 2'd2, 50, 5, DLY_STD, 4'hF, 3, 3, -1, 170);
    check_scalar("burst shot_cnt", 32'(shot_cnt), 3);
    run_seq("burst_reject", 2'd2, 50, 0, DLY_STD, 4'hF, 3, 0, -1, 20);
    check_scalar("burst_reject cfg_err", 32'(cfg_err), 1);
    check_scalar("burst_reject shot_cnt", 32'(shot_cnt), 3);
  endtask

  task automatic test_stop_mid_shot();
    run_seq("stop_mid", 2'd0, 100, 5, DLY_STD, 4'hF, 1, 2, 140, 230);
    check_scalar("stop_mid shot_cnt", 32'(shot_cnt), 2);
  endtask

  task automatic test_invalid_cfg();
    run_seq("invalid", 2'd0, 30, 5, DLY_BAD, 4'hF, 1, 0, -1, 40);
    check_scalar("invalid cfg_err", 32'(cfg_err), 1);
    run_seq("invalid_fixed", 2'd0, 30, 5, DLY_BAD, 4'b1011, 1, 2, 45, 80);
    check_scalar("invalid_fixed cfg_err", 32'(cfg_err), 0);
  endtask

  task automatic test_window_boundary();
    // delay + width equal to the period is the largest legal window
    run_seq("boundary", 2'd1, 30, 5, DLY_EDG, 4'hF, 1, 1, -1, 40);
    check_scalar("boundary cfg_err", 32'(cfg_err), 0);
    check_scalar("boundary shot_cnt", 32'(shot_cnt), 1);
  endtask

  task automatic test_start_stop_same();
    exp_t got;
    cfg_mode = 2'd0; cfg_period = CNT_W'(100); cfg_width = '0;
    cfg_delay = DLY_STD; cfg_burst = BURST_W'(1); ch_en = 4'hF;
    @(negedge clk);
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    for (int t = 1; t <= 20; t++) begin
      @(negedge clk);
      got = '{trig: trig_out, sync: sync_out, busy: busy};
      vectors++;
      if (got !== exp_t'('0)) begin
        miscompares++;
        $display("FAIL start_stop t=%0d: got %b, want 0", t, got);
      end
    end
    check_scalar("start_stop cfg_err", 32'(cfg_err), 0);
    check_scalar("start_stop shot_cnt", 32'(shot_cnt), 1);
  endtask

  task automatic test_reset_mid_pulse();
    exp_t got;
    cfg_mode = 2'd0; cfg_period = CNT_W'(100); cfg_width = PW_W'(5);
    cfg_delay = DLY_STD; cfg_burst = BURST_W'(1); ch_en = 4'hF;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_scalar("mid_pulse trig0 before rst", 32'(trig_out[0]), 1);
    #2 rst = 1'b1;
    #1;
    got = '{trig: trig_out, sync: sync_out, busy: busy};
    check_scalar("mid_pulse outputs in rst", 32'(got), 0);
    check_scalar("mid_pulse shot_cnt in rst", 32'(shot_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int t = 1; t <= 30; t++) begin
      @(negedge clk);
      got = '{trig: trig_out, sync: sync_out, busy: busy};
      vectors++;
      if (got !== exp_t'('0)) begin
        miscompares++;
        $display("FAIL post_rst t=%0d: got %b, want 0", t, got);
      end
    end
    check_scalar("post_rst shot_cnt", 32'(shot_cnt), 0);
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_single();
    test_burst();
    test_stop_mid_shot();
    test_invalid_cfg();
    test_window_boundary();
    test_start_stop_same();
    test_reset_mid_pulse();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
